store_queue_param: RTL and testbench

- Parameterised, circular store queue for the dual-dispatch LSU. Replaces the fixed-depth store queue.
- Allocates up to two entries per cycle in program order and accepts address/data writeback by entry index.
- Marks entries committed from the head (up to two per cycle), drains committed stores to the data-memory port over a valid/ready handshake, and squashes speculative entries on flush.

---
 rtl/store_queue_param.sv | 141 ++++++++++++++
 tb/tb_store_queue_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_param.sv
// Circular store queue for the dual-dispatch LSU: in-order dual allocation,
// indexed writeback, head-side commit, single-port drain and flush of speculative entries.
module store_queue_param #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid_1,
  input  logic              disp_valid_2,
  output logic              disp_ready,
  output logic [IDX_W-1:0]  disp_idx_1,
  output logic [IDX_W-1:0]  disp_idx_2,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              commit_1,
  input  logic              commit_2,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [IDX_W:0]    sq_count,
  output logic              sq_full,
  output logic              sq_empty
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [IDX_W:0]    head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, ready_q, ready_d, cmtd_q, cmtd_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [1:0]        req;
  logic [IDX_W:0]    free_slots;
  logic              alloc_fire, wb_ok, cmt_fire_1, cmt_fire_2, mem_fire;
  logic [IDX_W-1:0]  head_idx, cmt_idx_1, cmt_idx_2;
  logic [IDX_W:0]    cmt_p1;

  assign req        = {1'b0, disp_valid_1} + {1'b0, disp_valid_2};
  assign sq_count   = tail_q - head_q;
  assign free_slots = DEPTH_C - sq_count;
  assign sq_empty   = (tail_q == head_q);
  assign sq_full    = (tail_q[IDX_W] != head_q[IDX_W]) &&
                      (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]);

  // Capacity is judged on the pre-drain count, so a full queue refuses even while draining.
  assign disp_ready = (free_slots >= (IDX_W+1)'(req)) && !flush;
  assign alloc_fire = disp_ready && (req != 2'd0);
  assign disp_idx_1 = tail_q[IDX_W-1:0];
  assign disp_idx_2 = disp_idx_1 + IDX_W'(disp_valid_1);

  assign wb_ok      = wb_valid && valid_q[wb_idx] && !flush;
  assign cmt_fire_1 = commit_1 && !flush;
  assign cmt_fire_2 = cmt_fire_1 && commit_2;
  assign cmt_p1     = cmt_q + (IDX_W+1)'(1);
  assign cmt_idx_1  = cmt_q[IDX_W-1:0];
  assign cmt_idx_2  = cmt_p1[IDX_W-1:0];

  assign head_idx   = head_q[IDX_W-1:0];
  assign mem_valid  = valid_q[head_idx] & cmtd_q[head_idx] & ready_q[head_idx];
  assign mem_addr   = addr_q[head_idx];
  assign mem_data   = data_q[head_idx];
  assign mem_fire   = mem_valid && mem_ready;

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    cmtd_d  = cmtd_q;
    head_d  = head_q + (IDX_W+1)'(mem_fire);
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    if (mem_fire) begin
      valid_d[head_idx] = 1'b0;
      ready_d[head_idx] = 1'b0;
      cmtd_d[head_idx]  = 1'b0;
    end
    if (flush) begin
      // Every uncommitted valid entry lies in [cmt, tail); committed ones keep draining.
      for (int i = 0; i < DEPTH; i++) begin
        if (!cmtd_q[i]) begin
          valid_d[i] = 1'b0;
          ready_d[i] = 1'b0;
        end
      end
      tail_d = cmt_q;
    end else begin
      if (wb_ok) ready_d[wb_idx] = 1'b1;
      if (cmt_fire_1) cmtd_d[cmt_idx_1] = 1'b1;
      if (cmt_fire_2) cmtd_d[cmt_idx_2] = 1'b1;
      cmt_d = cmt_q + (IDX_W+1)'({cmt_fire_2, cmt_fire_1 & ~cmt_fire_2});
      if (alloc_fire) begin
        valid_d[disp_idx_1] = 1'b1;
        ready_d[disp_idx_1] = 1'b0;
        cmtd_d[disp_idx_1]  = 1'b0;
        if (req == 2'd2) begin
          valid_d[disp_idx_2] = 1'b1;
          ready_d[disp_idx_2] = 1'b0;
          cmtd_d[disp_idx_2]  = 1'b0;
        end
        tail_d = tail_q + (IDX_W+1)'(req);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      ready_q <= '0;
      cmtd_q  <= '0;
    end else begin
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cmtd_q  <= cmtd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_ok) begin
      addr_q[wb_idx] <= wb_addr;
      data_q[wb_idx] <= wb_data;
    end
  end

  a_commit_1_legal: assert property (@(posedge clk) disable iff (reset)
    cmt_fire_1 |-> (cmt_q != tail_q) && ready_q[cmt_idx_1]);
  a_commit_2_legal: assert property (@(posedge clk) disable iff (reset)
    cmt_fire_2 |-> (cmt_p1 != tail_q) && ready_q[cmt_idx_2]);

endmodule

// File: tb/tb_store_queue_param.sv
// Scenario bench for store_queue_param: a small pointer model predicts allocation results,
// and a queue of expected drains is compared against the memory port as stores leave.
module tb_store_queue_param;
  localparam int D = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        disp_valid_1 = 1'b0, disp_valid_2 = 1'b0, disp_ready;
  logic [2:0]  disp_idx_1, disp_idx_2;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_idx = '0;
  logic [31:0] wb_addr = '0, wb_data = '0;
  logic        commit_1 = 1'b0, commit_2 = 1'b0, flush = 1'b0;
  logic        mem_valid, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  sq_count;
  logic        sq_full, sq_empty;

  int errors = 0, checks = 0;
  int mh = 0, mc = 0, mt = 0;
  logic [31:0] m_addr [D];
  logic [31:0] m_data [D];
  logic [63:0] exp_q [$];

  store_queue_param #(.DEPTH(D), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_1(disp_valid_1), .disp_valid_2(disp_valid_2), .disp_ready(disp_ready),
    .disp_idx_1(disp_idx_1), .disp_idx_2(disp_idx_2),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_addr(wb_addr), .wb_data(wb_data),
    .commit_1(commit_1), .commit_2(commit_2), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .sq_count(sq_count), .sq_full(sq_full), .sq_empty(sq_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drain monitor: every accepted memory request must match the oldest expected store.
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got addr=%h data=%h, required none", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL drain_order: got %h/%h, required %h/%h", mem_addr, mem_data, e[63:32], e[31:0]);
        end
      end
      mh++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    disp_valid_1 = 0; disp_valid_2 = 0; wb_valid = 0; commit_1 = 0; commit_2 = 0;
    flush = 0; mem_ready = 0;
    cyc(); cyc();
    reset = 1'b0;
    exp_q.delete();
    mh = 0; mc = 0; mt = 0;
  endtask

  // Drives one allocation cycle; returns DUT outputs and the model's expected readiness.
  task automatic alloc(input logic v1, input logic v2, output logic rdy,
                       output logic [2:0] i1, output logic [2:0] i2,
                       output logic er, output logic [2:0] e1, output logic [2:0] e2);
    int req;
    req = int'(v1) + int'(v2);
    disp_valid_1 = v1; disp_valid_2 = v2;
    #1;
    rdy = disp_ready; i1 = disp_idx_1; i2 = disp_idx_2;
    er = ((D - (mt - mh)) >= req) && !flush;
    e1 = 3'(mt % D);
    e2 = (v1 && v2) ? 3'((mt + 1) % D) : e1;
    if (er) mt += req;
    cyc();
    disp_valid_1 = 0; disp_valid_2 = 0;
  endtask

  task automatic wb(input int idx, input logic [31:0] a, input logic [31:0] d);
    wb_valid = 1; wb_idx = 3'(idx); wb_addr = a; wb_data = d;
    m_addr[idx] = a; m_data[idx] = d;
    cyc();
    wb_valid = 0;
  endtask

  task automatic commit(input int n);
    commit_1 = 1; commit_2 = (n == 2);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({m_addr[(mc + k) % D], m_data[(mc + k) % D]});
    end
    mc += n;
    cyc();
    commit_1 = 0; commit_2 = 0;
  endtask

  task automatic wait_drained(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d stores pending, required 0", name, exp_q.size());
    end
  endtask

  logic rdy, er;
  logic [2:0] i1, i2, e1, e2;

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (sq_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", sq_empty); end
    if (sq_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", sq_full); end
    if (sq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", sq_count); end
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b required 0", mem_valid); end
    if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b required 1", disp_ready); end
  endtask

  task automatic test_alloc();
    for (int k = 0; k < 2; k++) begin
      alloc(1, 1, rdy, i1, i2, er, e1, e2);
      checks += 3;
      if (rdy !== er) begin errors++; $display("FAIL alloc_ready%0d: got %b required %b", k, rdy, er); end
      if (i1 !== e1) begin errors++; $display("FAIL alloc_idx1_%0d: got %0d required %0d", k, i1, e1); end
      if (i2 !== e2) begin errors++; $display("FAIL alloc_idx2_%0d: got %0d required %0d", k, i2, e2); end
    end
    checks++;
    if (sq_count !== 4'd4) begin errors++; $display("FAIL alloc_count: got %0d required 4", sq_count); end
  endtask

  task automatic test_drain();
    wb(0, 32'h100, 32'hAA);
    mem_ready = 1;
    commit(1);
    checks += 3;
    if (mem_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b required 1", mem_valid); end
    if (mem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr: got %h required 100", mem_addr); end
    if (mem_data !== 32'hAA) begin errors++; $display("FAIL drain_data: got %h required aa", mem_data); end
    cyc();
    checks++;
    if (sq_count !== 4'(mt - mh)) begin errors++; $display("FAIL drain_count: got %0d required %0d", sq_count, mt - mh); end
  endtask

  task automatic test_full();
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    checks += 3;
    if (rdy !== 1'b1 || i1 !== e1) begin errors++; $display("FAIL fill_last: got rdy=%b idx=%0d required 1/%0d", rdy, i1, e1); end
    if (sq_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b required 1", sq_full); end
    if (sq_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d required 8", sq_count); end
    wb(1, 32'h104, 32'hBB);
    commit(1);
    // Drain is pending this cycle; the full queue must still refuse the request.
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    checks += 2;
    if (rdy !== 1'b0) begin errors++; $display("FAIL full_while_drain: got rdy=%b required 0", rdy); end
    if (sq_count !== 4'd7) begin errors++; $display("FAIL full_after_drain: got %0d required 7", sq_count); end
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    checks += 2;
    if (rdy !== 1'b0) begin errors++; $display("FAIL dual_one_free: got rdy=%b required 0", rdy); end
    if (sq_count !== 4'd7) begin errors++; $display("FAIL dual_one_free_count: got %0d required 7", sq_count); end
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    checks += 2;
    if (rdy !== 1'b1 || i1 !== 3'd1) begin errors++; $display("FAIL single_one_free: got rdy=%b idx=%0d required 1/1", rdy, i1); end
    if (sq_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b required 1", sq_full); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    wb(0, 32'h200, 32'h11);
    wb(1, 32'h204, 32'h22);
    commit(2);
    flush = 1; disp_valid_1 = 1;
    #1;
    checks++;
    if (disp_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_alloc: got %b required 0", disp_ready); end
    cyc();
    flush = 0; disp_valid_1 = 0;
    mt = mc;
    checks++;
    if (sq_count !== 4'd2) begin errors++; $display("FAIL flush_count: got %0d required 2", sq_count); end
    mem_ready = 1;
    wait_drained("flush");
    checks++;
    if (sq_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b required 1", sq_empty); end
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    checks++;
    if (rdy !== 1'b1 || i1 !== 3'd2) begin errors++; $display("FAIL flush_realloc: got rdy=%b idx=%0d required 1/2", rdy, i1); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 3; k++) alloc(1, 1, rdy, i1, i2, er, e1, e2);
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    for (int k = 0; k < 7; k++) wb(k, 32'h1000 + 32'(k), 32'hC0 + 32'(k));
    mem_ready = 1;
    commit(2); commit(2); commit(2); commit(1);
    wait_drained("prewrap");
    alloc(1, 1, rdy, i1, i2, er, e1, e2);
    checks += 2;
    if (rdy !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b required 1", rdy); end
    if (i1 !== 3'd7 || i2 !== 3'd0) begin errors++; $display("FAIL wrap_idx: got (%0d,%0d) required (7,0)", i1, i2); end
    wb(7, 32'h700, 32'h77);
    wb(0, 32'h800, 32'h88);
    commit(2);
    wait_drained("wrap");
    alloc(0, 1, rdy, i1, i2, er, e1, e2);
    checks += 2;
    if (rdy !== 1'b1) begin errors++; $display("FAIL way2_only_ready: got %b required 1", rdy); end
    if (i1 !== 3'd1 || i2 !== 3'd1) begin errors++; $display("FAIL way2_only_idx: got (%0d,%0d) required (1,1)", i1, i2); end
  endtask

  task automatic test_hold_reset();
    do_reset();
    alloc(1, 0, rdy, i1, i2, er, e1, e2);
    wb(0, 32'hA5A5_0000, 32'h5A5A_1234);
    commit_2 = 1;
    cyc();
    commit_2 = 0;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL commit2_alone: got mem_valid=%b required 0", mem_valid); end
    commit(1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b required 0", mem_valid); end
        if (sq_count !== 4'd0) begin errors++; $display("FAIL async_reset_count: got %0d required 0", sq_count); end
        if (sq_empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty: got %b required 1", sq_empty); end
        if (sq_full !== 1'b0) begin errors++; $display("FAIL async_reset_full: got %b required 0", sq_full); end
        break;
      end
      checks += 3;
      if (mem_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b required 1", c, mem_valid); end
      if (mem_addr !== 32'hA5A5_0000) begin errors++; $display("FAIL hold_addr%0d: got %h required a5a50000", c, mem_addr); end
      if (mem_data !== 32'h5A5A_1234) begin errors++; $display("FAIL hold_data%0d: got %h required 5a5a1234", c, mem_data); end
      cyc();
    end
    cyc();
    exp_q.delete();
    mh = 0; mc = 0; mt = 0;
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_drain();
    test_full();
    test_flush();
    test_wrap();
    test_hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
